// File: rtl/ledge_mover.sv
// Frame-rate motion controller for one moving ledge: horizontal sweep between
// X_MIN and X_MAX with a dwell at each end. Optional vertical bob under LEDGE_BOB_EN.
module ledge_mover #(
  parameter logic [9:0] X_MIN        = 10'd100,
  parameter logic [9:0] X_MAX        = 10'd540,
  parameter logic [9:0] X_START      = 10'd320,
  parameter logic [9:0] Y_HOME       = 10'd300,
  parameter logic [9:0] STEP         = 10'd2,
  parameter logic [7:0] DWELL_FRAMES = 8'd30,
  parameter logic [9:0] BOB_AMP      = 10'd8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  output logic [9:0] ledgeX,
  output logic [9:0] ledgeY,
  output logic       moving,
  output logic       dir_right
);

  localparam logic [1:0] MOVE_R  = 2'd0;
  localparam logic [1:0] DWELL_R = 2'd1;
  localparam logic [1:0] MOVE_L  = 2'd2;
  localparam logic [1:0] DWELL_L = 2'd3;

  logic       fs_q, fd_q;
  logic       tick, advance;
  logic [1:0] state_q, state_d;
  logic [9:0] posX_q, posX_d;
  logic [7:0] dwellCnt_q, dwellCnt_d;
  logic       moving_q, dirRight_q;
  logic [10:0] sumRight, limitLeft;

  // frame_clk is asynchronous; sync it and detect its rising edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      fs_q <= frame_clk;
      fd_q <= fs_q;
    end
  end

  assign tick    = fs_q & ~fd_q;
  assign advance = tick & enable;

  assign sumRight  = {1'b0, posX_q} + {1'b0, STEP};
  assign limitLeft = {1'b0, X_MIN} + {1'b0, STEP};

  always_comb begin
    state_d    = state_q;
    posX_d     = posX_q;
    dwellCnt_d = dwellCnt_q;
    if (advance) begin
      case (state_q)
        MOVE_R: begin
          if (sumRight >= {1'b0, X_MAX}) begin
            posX_d     = X_MAX;
            state_d    = DWELL_R;
            dwellCnt_d = DWELL_FRAMES;
          end else begin
            posX_d = sumRight[9:0];
          end
        end
        MOVE_L: begin
          // Compare before subtracting so X can never wrap below X_MIN.
          if ({1'b0, posX_q} <= limitLeft) begin
            posX_d     = X_MIN;
            state_d    = DWELL_L;
            dwellCnt_d = DWELL_FRAMES;
          end else begin
            posX_d = posX_q - STEP;
          end
        end
        DWELL_R: begin
          if (dwellCnt_q == 8'd0) state_d = MOVE_L;
          else                    dwellCnt_d = dwellCnt_q - 8'd1;
        end
        default: begin
          if (dwellCnt_q == 8'd0) state_d = MOVE_R;
          else                    dwellCnt_d = dwellCnt_q - 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= MOVE_R;
      posX_q     <= X_START;
      dwellCnt_q <= 8'd0;
      moving_q   <= 1'b1;
      dirRight_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      posX_q     <= posX_d;
      dwellCnt_q <= dwellCnt_d;
      moving_q   <= (state_d == MOVE_R) || (state_d == MOVE_L);
      dirRight_q <= (state_d == MOVE_R) || (state_d == DWELL_R);
    end
  end

  assign ledgeX    = posX_q;
  assign moving    = moving_q;
  assign dir_right = dirRight_q;

`ifdef LEDGE_BOB_EN
  logic       bobUp_q, bobUp_d;
  logic [9:0] bobOff_q, bobOff_d;
  logic [9:0] posY_q;

  // Triangle wave between 0 and BOB_AMP, reversing on the tick that reaches an end.
  always_comb begin
    bobUp_d  = bobUp_q;
    bobOff_d = bobOff_q;
    if (advance) begin
      if (bobUp_q) begin
        bobOff_d = bobOff_q + 10'd1;
        if (bobOff_d >= BOB_AMP) bobUp_d = 1'b0;
      end else begin
        bobOff_d = bobOff_q - 10'd1;
        if (bobOff_d == 10'd0) bobUp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bobUp_q  <= 1'b1;
      bobOff_q <= 10'd0;
      posY_q   <= Y_HOME;
    end else begin
      bobUp_q  <= bobUp_d;
      bobOff_q <= bobOff_d;
      posY_q   <= Y_HOME - bobOff_d;
    end
  end

  assign ledgeY = posY_q;
`else
  logic unusedBobAmp;
  assign unusedBobAmp = ^BOB_AMP;
  assign ledgeY       = Y_HOME;
`endif

endmodule

// File: tb/tb_ledge_mover.sv
// Directed self-checking bench for ledge_mover; a second instance with STEP=7
// and X_START=535 exercises the bound clamping.
module tb_ledge_mover;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       enable;
  logic [9:0] ledgeX, ledgeY;
  logic       moving, dir_right;
  logic [9:0] clampX, clampY;
  logic       clampMoving, clampDirRight;

  int compared   = 0;
  int mismatched = 0;

  ledge_mover dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .ledgeX(ledgeX), .ledgeY(ledgeY), .moving(moving), .dir_right(dir_right)
  );

  ledge_mover #(.X_START(10'd535), .STEP(10'd7)) dutClamp (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .ledgeX(clampX), .ledgeY(clampY), .moving(clampMoving), .dir_right(clampDirRight)
  );

  always #5 Clk = ~Clk;

  // One frame: high two cycles (output updates on the second edge), low two cycles.
  task automatic applyStimulus(input int frames);
    for (int i = 0; i < frames; i++) begin
      frame_clk = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      frame_clk = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyReset();
    Reset     = 1'b1;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_step_latency();
    applyReset();
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    compared++;
    if (ledgeX !== 10'd320) begin mismatched++; $display("[TB] FAIL step_edge1 ledgeX got %0d want 320", ledgeX); end
    @(posedge Clk); #1;
    compared++;
    if (ledgeX !== 10'd322) begin mismatched++; $display("[TB] FAIL step_edge2 ledgeX got %0d want 322", ledgeX); end
    repeat (48) @(posedge Clk);
    #1;
    compared++;
    if (ledgeX !== 10'd322) begin mismatched++; $display("[TB] FAIL step_held ledgeX got %0d want 322", ledgeX); end
    frame_clk = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    compared++;
    if (ledgeX !== 10'd322) begin mismatched++; $display("[TB] FAIL step_low ledgeX got %0d want 322", ledgeX); end
  endtask

  task automatic test_right_bound();
    applyReset();
    applyStimulus(109);
    compared++;
    if (ledgeX !== 10'd538 || moving !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bound_f109 ledgeX/moving got %0d/%0b want 538/1", ledgeX, moving);
    end
    applyStimulus(1);
    compared++;
    if (ledgeX !== 10'd540 || moving !== 1'b0 || dir_right !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bound_f110 x/mov/dir got %0d/%0b/%0b want 540/0/1", ledgeX, moving, dir_right);
    end
    applyStimulus(30);
    compared++;
    if (ledgeX !== 10'd540 || moving !== 1'b0 || dir_right !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bound_f140 x/mov/dir got %0d/%0b/%0b want 540/0/1", ledgeX, moving, dir_right);
    end
    applyStimulus(1);
    compared++;
    if (ledgeX !== 10'd540 || moving !== 1'b1 || dir_right !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bound_f141 x/mov/dir got %0d/%0b/%0b want 540/1/0", ledgeX, moving, dir_right);
    end
    applyStimulus(1);
    compared++;
    if (ledgeX !== 10'd538 || dir_right !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bound_f142 x/dir got %0d/%0b want 538/0", ledgeX, dir_right);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    applyStimulus(5);
    compared++;
    if (ledgeX !== 10'd538 || moving !== 1'b1 || dir_right !== 1'b0) begin
      mismatched++; $display("[TB] FAIL enable_low x/mov/dir got %0d/%0b/%0b want 538/1/0", ledgeX, moving, dir_right);
    end
    enable = 1'b1;
    applyStimulus(1);
    compared++;
    if (ledgeX !== 10'd536) begin mismatched++; $display("[TB] FAIL enable_resume ledgeX got %0d want 536", ledgeX); end
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    compared++;
    if (ledgeX !== 10'd320 || ledgeY !== 10'd300 || moving !== 1'b1 || dir_right !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_first x/y/mov/dir got %0d/%0d/%0b/%0b want 320/300/1/1", ledgeX, ledgeY, moving, dir_right);
    end
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    compared++;
    if (ledgeX !== 10'd320 || dir_right !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_after x/dir got %0d/%0b want 320/1", ledgeX, dir_right);
    end
  endtask

  task automatic test_clamp();
    applyReset();
    compared++;
    if (clampX !== 10'd535) begin mismatched++; $display("[TB] FAIL clamp_reset clampX got %0d want 535", clampX); end
    applyStimulus(1);
    compared++;
    if (clampX !== 10'd540 || clampMoving !== 1'b0) begin
      mismatched++; $display("[TB] FAIL clamp_right x/mov got %0d/%0b want 540/0", clampX, clampMoving);
    end
    applyStimulus(99);
    compared++;
    if (clampX !== 10'd100 || clampMoving !== 1'b0 || clampDirRight !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clamp_left x/mov/dir got %0d/%0b/%0b want 100/0/0", clampX, clampMoving, clampDirRight);
    end
  endtask

  task automatic test_bob();
    logic [9:0] expY;
    applyReset();
    compared++;
    if (ledgeY !== 10'd300) begin mismatched++; $display("[TB] FAIL bob_reset ledgeY got %0d want 300", ledgeY); end
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1);
`ifdef LEDGE_BOB_EN
      expY = (k <= 8) ? 10'(300 - k) : 10'(300 - (16 - k));
`else
      expY = 10'd300;
`endif
      compared++;
      if (ledgeY !== expY) begin
        mismatched++; $display("[TB] FAIL bob_frame%0d ledgeY got %0d want %0d", k, ledgeY, expY);
      end
    end
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    enable    = 1'b1;
    test_step_latency();
    test_right_bound();
    test_enable();
    test_reset();
    test_clamp();
    test_bob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ledge_mover.md
# ledge_mover

Frame-rate motion controller that generates the centre coordinates of one moving ledge. Sits directly upstream of the ledge renderer and drives its `ledgeX`/`ledgeY` inputs. The ledge sweeps horizontally between two bounds, pausing at each end. One update per video frame, so the renderer and the fighter collision logic see a position that is stable for a whole frame.

## Interface

Parameters:
- `X_MIN`, 10'd100: left bound of the ledge centre.
- `X_MAX`, 10'd540: right bound of the ledge centre.
- `X_START`, 10'd320: centre X after reset; must lie within [X_MIN, X_MAX].
- `Y_HOME`, 10'd300: centre Y after reset, and the base Y.
- `STEP`, 10'd2: pixels moved per frame while moving; nonzero.
- `DWELL_FRAMES`, 8'd30: frames paused at each bound.
- `BOB_AMP`, 10'd8: vertical bob amplitude in pixels. Used only with the macro.

Ports:
- `Clk`, input, 1: system clock.
- `Reset`, input, 1: synchronous, active-high.
- `frame_clk`, input, 1: vsync-rate frame strobe, asynchronous to `Clk`.
- `enable`, input, 1: motion enable. Low freezes all state.
- `ledgeX`, output, 10: ledge centre X, registered.
- `ledgeY`, output, 10: ledge centre Y, registered.
- `moving`, output, 1: 1 in MOVE_R or MOVE_L, registered.
- `dir_right`, output, 1: 1 in MOVE_R or DWELL_R, registered.

## Operation

- **Frame tick generation**
  - Two-flop sync: `fs <= frame_clk`, `fd <= fs`.
  - `tick = fs & ~fd`, which gives one `Clk` cycle per rising edge of `frame_clk`.
  - All state updates occur only on a `Clk` edge where `tick & enable` is true.
- **FSM states:** MOVE_R, DWELL_R, MOVE_L, DWELL_L. The 8-bit `dwell_cnt` is the dwell counter.
- **MOVE_R**
  - Compute `sum = {1'b0,ledgeX} + STEP` at 11 bits.
  - If `sum >= X_MAX`: set `ledgeX = X_MAX`, go to DWELL_R, load `dwell_cnt = DWELL_FRAMES`.
  - Otherwise: `ledgeX = sum[9:0]`.
- **MOVE_L**
  - If `ledgeX <= X_MIN + STEP` (11-bit compare): set `ledgeX = X_MIN`, go to DWELL_L, load `dwell_cnt = DWELL_FRAMES`.
  - Otherwise: `ledgeX = ledgeX - STEP`.
  - Never underflows below X_MIN.
- **DWELL_R / DWELL_L**
  - On tick with `dwell_cnt == 0`: go to MOVE_L / MOVE_R respectively.
  - Otherwise: decrement `dwell_cnt`.
  - `ledgeX` is held throughout.
  - With DWELL_FRAMES=0, the first tick after arrival starts motion in the opposite direction. No X change occurs on that tick.
- **`enable` low:** ticks are ignored. State, counter and outputs hold. On re-enable, motion resumes from the held state with no catch-up.
- **Reset (any cycle, including mid-dwell or mid-tick):**
  - `ledgeX = X_START`, `ledgeY = Y_HOME`.
  - State MOVE_R, `dwell_cnt = 0`, `moving = 1`, `dir_right = 1`.
  - `fs = fd = 0`.
  - Reset has priority over the tick.
- **Bound case:** X_START equal to X_MAX is legal. The first tick moves to DWELL_R.

## Timing

- A `frame_clk` rise is captured into `fs` at `Clk` edge 1. `tick` is high during the following cycle. Outputs update at edge 2.
- Latency is therefore 2 `Clk` edges from the rising edge of `frame_clk` to the output change.
- Exactly one update per `frame_clk` rising edge. `frame_clk` high or low for any number of cycles causes no further updates.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `moving` and `dir_right` change on the same edge as the state transition.

## Configuration

- **With `LEDGE_BOB_EN` defined:**
  - A second state bit `bob_up` and a 10-bit `bob_off` (reset value 0, `bob_up` = 1) are added.
  - Each `tick & enable`, `bob_off` steps by 1 toward BOB_AMP when rising, or toward 0 when falling.
  - Direction reverses on the tick that reaches BOB_AMP or 0.
  - `ledgeY = Y_HOME - bob_off`, giving a triangle wave with period 2·BOB_AMP frames.
  - The bob is independent of the X FSM and continues during dwell.
- **Without `LEDGE_BOB_EN`:** `ledgeY` is constantly Y_HOME and no bob logic is synthesised.

## Test plan

- **Reset:** Reset high for 3 cycles mid-run -> `ledgeX` = 320, `ledgeY` = 300, `moving` = 1, `dir_right` = 1 on the first edge with Reset sampled.
- **Step and latency:** one `frame_clk` pulse held for 50 cycles -> `ledgeX` goes 320→322 exactly 2 edges after the rise, then stays unchanged.
- **Right bound:** 110 frames from reset -> `ledgeX` reaches 540 at frame 110 with `moving` = 0. It holds 540 for frames 111–141 (30 ticks decrement, the 31st transitions). Frame 142 -> 538, `dir_right` = 0.
- **Clamp:** STEP=7, X_START=535, 1 frame -> `ledgeX` = 540, not 542. Left sweep with STEP=7 -> `ledgeX` ends at exactly 100.
- **Enable:** `enable` low across 5 frames during MOVE_L -> no change. Re-enable plus 1 frame -> X decreases by exactly 2.
- **LEDGE_BOB_EN (macro defined, BOB_AMP = 8):** 16 frames from reset -> `ledgeY` goes 300→292 over frames 1–8 and back to 300 at frame 16. Without the macro, `ledgeY` = 300 throughout.
